// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM/frame-class enums,
// the fallback ASCII code, and a constant-evaluable ceil(log2) helper.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEB, HELD} state_e;
  typedef enum logic [1:0] {NONE, ONE, MULTI} frame_cls_e;

  localparam logic [6:0] ASCII_QMARK = 7'h3F;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/keymap_ascii.sv
// Combinational key index -> ASCII lookup; only the 4x4 telephone layout
// has a table, every other geometry reports '?'.
module keymap_ascii
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic [clog2(ROWS*COLS)-1:0] key_code,
  output logic [6:0]                  ascii
);

  if (ROWS == 4 && COLS == 4) begin : g_4x4
    localparam logic [6:0] LUT [16] = '{
      7'h31, 7'h32, 7'h33, 7'h41,
      7'h34, 7'h35, 7'h36, 7'h42,
      7'h37, 7'h38, 7'h39, 7'h43,
      7'h2A, 7'h30, 7'h23, 7'h44
    };
    assign ascii = LUT[key_code];
  end else begin : g_other
    assign ascii = ASCII_QMARK;
  end

endmodule

// File: rtl/keypad_scanner_fifo.sv
// Matrix keypad scanner: one-hot row drive, per-frame debounce with ghost
// rejection, optional auto-repeat, and a small event FIFO on valid/ready.
module keypad_scanner_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned SCAN_HZ         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_FRAMES   = 0,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                        clk50,
  input  logic                        rst,
  input  logic [COLS-1:0]             Columna,
  output logic [ROWS-1:0]             Fila,
  output logic [clog2(ROWS*COLS)-1:0] key_code,
  output logic [6:0]                  ascii,
  output logic                        isDone,
  input  logic                        rd_ready,
  output logic                        key_held,
  output logic                        overflow
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned KW   = clog2(N);
  localparam int unsigned NW   = clog2(N + 1);
  localparam int unsigned TP   = CLK_HZ / SCAN_HZ;
  localparam int unsigned TW   = clog2(TP);
  localparam int unsigned RW   = clog2(ROWS);
  localparam int unsigned MAXF = (DEBOUNCE_FRAMES > REPEAT_FRAMES) ? DEBOUNCE_FRAMES : REPEAT_FRAMES;
  localparam int unsigned CW   = clog2(MAXF + 1);
  localparam int unsigned AW   = clog2(FIFO_DEPTH);
  localparam int unsigned EW   = KW + 7;

  localparam logic [CW-1:0] DEB_N   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] REP_N   = CW'(REPEAT_FRAMES);
  localparam logic [AW:0]   DEPTH_N = (AW+1)'(FIFO_DEPTH);

  // ---------------- scan / frame capture ----------------
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] fila_q, fila_d;
  logic [COLS-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [N-1:0]    acc_q, acc_d, frame_q, frame_d;
  logic            frame_vld_q, frame_vld_d;
  logic            tick;

  always_comb begin
    tick        = (tick_cnt_q == TW'(TP - 1));
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    col_s1_d    = Columna;
    col_s2_d    = col_s1_q;
    row_d       = row_q;
    fila_d      = fila_q;
    acc_d       = acc_q;
    frame_d     = frame_q;
    frame_vld_d = 1'b0;
    if (tick) begin
      acc_d[row_q*COLS +: COLS] = col_s2_q;
      fila_d = {fila_q[ROWS-2:0], fila_q[ROWS-1]};
      if (row_q == RW'(ROWS - 1)) begin
        row_d       = '0;
        frame_d     = acc_d;
        acc_d       = '0;
        frame_vld_d = 1'b1;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      row_q       <= '0;
      fila_q      <= ROWS'(1);
      col_s1_q    <= '0;
      col_s2_q    <= '0;
      acc_q       <= '0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      row_q       <= row_d;
      fila_q      <= fila_d;
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      acc_q       <= acc_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
    end
  end

  assign Fila = fila_q;

  // ---------------- frame classification ----------------
  logic [NW-1:0] ones;
  logic [KW-1:0] one_idx;
  frame_cls_e    cls;

  always_comb begin
    ones    = '0;
    one_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (frame_q[i]) begin
        ones    = ones + NW'(1);
        one_idx = KW'(i);
      end
    end
    if (ones == '0)          cls = NONE;
    else if (ones == NW'(1)) cls = ONE;
    else                     cls = MULTI;
  end

  // ---------------- debounce / repeat FSM ----------------
  state_e        state_q, state_d;
  logic [KW-1:0] cand_q, cand_d, push_key;
  logic [CW-1:0] deb_q, deb_d, rep_q, rep_d, rel_q, rel_d;
  logic          push, hit;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      deb_q   <= '0;
      rep_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      rep_q   <= rep_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    deb_d    = deb_q;
    rep_d    = rep_q;
    rel_d    = rel_q;
    push     = 1'b0;
    push_key = cand_q;
    hit      = (cls == ONE) && (one_idx == cand_q);
    if (frame_vld_q) begin
      case (state_q)
        IDLE: if (cls == ONE) begin
          cand_d   = one_idx;
          push_key = one_idx;
          deb_d    = CW'(1);
          if (DEB_N == CW'(1)) begin
            push    = 1'b1;
            state_d = HELD;
            rep_d   = '0;
            rel_d   = '0;
          end else begin
            state_d = DEB;
          end
        end
        DEB: if (hit) begin
          deb_d = deb_q + CW'(1);
          if (deb_q + CW'(1) == DEB_N) begin
            push    = 1'b1;
            state_d = HELD;
            rep_d   = '0;
            rel_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
        HELD: if (hit) begin
          rel_d = '0;
          if (REPEAT_FRAMES > 0) begin
            if (rep_q + CW'(1) == REP_N) begin
              push  = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + CW'(1);
            end
          end
        end else if (cls == NONE) begin
          rel_d = rel_q + CW'(1);
          if (rel_q + CW'(1) == DEB_N) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    key_held = (state_q == HELD);
  end

  // ---------------- event FIFO ----------------
  logic [6:0]    push_ascii;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, empty, pop, wr_en;

  keymap_ascii #(.ROWS(ROWS), .COLS(COLS)) u_keymap (
    .key_code (push_key),
    .ascii    (push_ascii)
  );

  always_comb begin
    full  = (count_q == DEPTH_N);
    empty = (count_q == '0);
    pop   = !empty && rd_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    wr_en = push && (!full || pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = {push_key, push_ascii};
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!wr_en && pop) count_d = count_q - (AW+1)'(1);
    overflow_d = overflow_q | (push && full && !pop);
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign isDone   = !empty;
  assign key_code = empty ? '0 : head[EW-1:7];
  assign ascii    = empty ? '0 : head[6:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Directed bench: two scanner instances (repeat off / repeat every 3 frames)
// driven by a behavioural keypad model that follows each instance's row drive.
module tb_keypad_scanner_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0, keys2 = '0;
  logic [3:0]  fila1, col1, code1, fila2, col2, code2;
  logic [6:0]  asc1, asc2;
  logic        done1, held1, ovf1, rdy1 = 1'b0;
  logic        done2, held2, ovf2, rdy2 = 1'b0;
  int          n_err = 0, n_checks = 0, rep_events = 0;

  always #5 clk = ~clk;

  keypad_scanner_fifo #(
    .ROWS(4), .COLS(4), .CLK_HZ(1000), .SCAN_HZ(250),
    .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(0), .FIFO_DEPTH(4)
  ) dut (
    .clk50(clk), .rst(rst), .Columna(col1), .Fila(fila1), .key_code(code1),
    .ascii(asc1), .isDone(done1), .rd_ready(rdy1), .key_held(held1), .overflow(ovf1)
  );

  keypad_scanner_fifo #(
    .ROWS(4), .COLS(4), .CLK_HZ(1000), .SCAN_HZ(250),
    .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(3), .FIFO_DEPTH(4)
  ) dut_rep (
    .clk50(clk), .rst(rst), .Columna(col2), .Fila(fila2), .key_code(code2),
    .ascii(asc2), .isDone(done2), .rd_ready(rdy2), .key_held(held2), .overflow(ovf2)
  );

  // pressed key at index r*4+c connects row r to column c
  always_comb begin
    col1 = '0;
    col2 = '0;
    for (int r = 0; r < 4; r++) begin
      if (fila1[r]) col1 = col1 | keys[r*4 +: 4];
      if (fila2[r]) col2 = col2 | keys2[r*4 +: 4];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to the start (row 0, first cycle) of the next scan frame
  task automatic sync_frame();
    int n = 0;
    while (fila1 != 4'b1000 && n < 40) begin @(negedge clk); n++; end
    while (fila1 != 4'b0001 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check("frame_sync_timeout", 32'(n), 32'd0);
  endtask

  task automatic hold(input logic [15:0] k, input int n, input bit inst2);
    if (inst2) begin keys2 = k; keys = '0; end
    else       begin keys = k;  keys2 = '0; end
    repeat (n) sync_frame();
  endtask

  task automatic pop1();
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done2 && rdy2) begin
      rep_events++;
      check("rep_code", 32'(code2), 32'd15);
      check("rep_ascii", 32'(asc2), 32'h44);
    end
  end

  logic [3:0]  exp_fila;
  logic [15:0] one16;
  int          codes [5] = '{1, 2, 3, 4, 12};
  logic [6:0]  ascs  [5] = '{7'h32, 7'h33, 7'h41, 7'h34, 7'h2A};

  initial begin
    one16 = 16'h0001;
    // 1: reset values, then idle row rotation
    repeat (2) @(negedge clk);
    check("rst_fila", 32'(fila1), 32'd1);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_code", 32'(code1), 32'd0);
    check("rst_ascii", 32'(asc1), 32'd0);
    check("rst_held", 32'(held1), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_fila = 4'b0001 << ((k / 4) % 4);
      check("idle_fila", 32'(fila1), 32'(exp_fila));
      check("idle_done", 32'(done1), 32'd0);
      check("idle_ovf", 32'(ovf1), 32'd0);
      @(negedge clk);
    end

    // 2: key 9 held 3 frames, then released
    sync_frame();
    hold(one16 << 9, 3, 1'b0);
    check("k9_done", 32'(done1), 32'd1);
    check("k9_code", 32'(code1), 32'd9);
    check("k9_ascii", 32'(asc1), 32'h38);
    check("k9_held", 32'(held1), 32'd1);
    hold('0, 3, 1'b0);
    check("k9_released", 32'(held1), 32'd0);
    check("k9_still_one", 32'(done1), 32'd1);
    pop1();
    check("k9_no_second", 32'(done1), 32'd0);

    // 3: one-frame bounce, twice, never becomes an event
    hold(one16 << 6, 1, 1'b0);
    hold('0, 2, 1'b0);
    check("bounce_done", 32'(done1), 32'd0);
    check("bounce_held", 32'(held1), 32'd0);
    hold(one16 << 6, 1, 1'b0);
    hold('0, 2, 1'b0);
    check("bounce_idle", 32'(done1), 32'd0);

    // 4: ghost frame (keys 0 and 5), then key 5 alone
    hold(16'h0021, 4, 1'b0);
    check("multi_done", 32'(done1), 32'd0);
    check("multi_held", 32'(held1), 32'd0);
    hold(one16 << 5, 2, 1'b0);
    hold('0, 1, 1'b0);
    check("k5_done", 32'(done1), 32'd1);
    check("k5_code", 32'(code1), 32'd5);
    check("k5_ascii", 32'(asc1), 32'h35);
    hold('0, 2, 1'b0);
    pop1();
    check("k5_popped", 32'(done1), 32'd0);

    // 5: auto-repeat every 3 frames on the second instance
    rdy2 = 1'b1;
    rep_events = 0;
    hold(one16 << 15, 12, 1'b1);
    hold('0, 3, 1'b1);
    check("rep_events", 32'(rep_events), 32'd4);
    check("rep_ovf", 32'(ovf2), 32'd0);
    rdy2 = 1'b0;

    // 6: five presses into a depth-4 FIFO, drain, reset mid-debounce
    for (int i = 0; i < 5; i++) begin
      hold(one16 << codes[i], 2, 1'b0);
      hold('0, 2, 1'b0);
      if (i == 3) check("fill_ovf_clear", 32'(ovf1), 32'd0);
    end
    check("fill_ovf_set", 32'(ovf1), 32'd1);
    rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_done", 32'(done1), 32'd1);
      check("drain_code", 32'(code1), 32'(codes[i]));
      check("drain_ascii", 32'(asc1), 32'(ascs[i]));
      @(negedge clk);
    end
    rdy1 = 1'b0;
    check("drain_empty", 32'(done1), 32'd0);
    check("drain_ovf_sticky", 32'(ovf1), 32'd1);
    sync_frame();
    hold(one16 << 8, 2, 1'b0);
    hold('0, 2, 1'b0);
    check("k8_code", 32'(code1), 32'd8);
    check("k8_ascii", 32'(asc1), 32'h37);
    hold(one16 << 7, 1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_fila", 32'(fila1), 32'd1);
    check("mid_rst_code", 32'(code1), 32'd0);
    check("mid_rst_ascii", 32'(asc1), 32'd0);
    check("mid_rst_done", 32'(done1), 32'd0);
    check("mid_rst_held", 32'(held1), 32'd0);
    check("mid_rst_ovf", 32'(ovf1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(one16 << 7, 1, 1'b0);
    hold('0, 2, 1'b0);
    check("post_rst_no_event", 32'(done1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
